// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running H/V counters, delayed syncs, strobes.
// Ports: i_Clk, i_Rst_L, i_Enable in; counters, syncs, visible, strobes out.
module vga_timing_generator #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int SYNC_DELAY     = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  output logic [9:0] o_H_Counter,
  output logic [9:0] o_V_Counter,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Visible,
  output logic       o_Line_Start,
  output logic       o_Frame_Start
);

  localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH
                         + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH
                         + V_SYNC_PULSE + V_BACK_PORCH;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_generator: totals exceed 10-bit counters");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
      $error("vga_timing_generator: SYNC_DELAY out of range 0..7");
    end
  endgenerate

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE_AREA);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE_AREA);
  localparam logic [9:0] H_SS   =
    10'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [9:0] H_SE   =
    10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [9:0] V_SS   =
    10'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [9:0] V_SE   =
    10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       line_q;
  logic       frame_q;
  logic       hs_raw;
  logic       vs_raw;
  logic       vis_raw;

  assign h_wrap = i_Enable && (h_cnt == H_LAST);
  assign v_wrap = h_wrap && (v_cnt == V_LAST);

  // Strobes are loaded from the wrap condition, so they are high only
  // in the cycle right after the wrapping edge, and a stall clears them.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= h_wrap;
      frame_q <= v_wrap;
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end else if (i_Enable) begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign hs_raw  = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs_raw  = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign vis_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign o_HSync   = hs_raw;
      assign o_VSync   = vs_raw;
      assign o_Visible = vis_raw;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hs_sr;
      logic [SYNC_DELAY-1:0] vs_sr;
      logic [SYNC_DELAY-1:0] vis_sr;

      // Shifts every clock so the syncs keep pace with the
      // renderer pipeline even while the counters are stalled.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          hs_sr  <= '1;
          vs_sr  <= '1;
          vis_sr <= '0;
        end else begin
          hs_sr[0]  <= hs_raw;
          vs_sr[0]  <= vs_raw;
          vis_sr[0] <= vis_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
            vis_sr[i] <= vis_sr[i-1];
          end
        end
      end

      assign o_HSync   = hs_sr[SYNC_DELAY-1];
      assign o_VSync   = vs_sr[SYNC_DELAY-1];
      assign o_Visible = vis_sr[SYNC_DELAY-1];
    end
  endgenerate

  assign o_H_Counter   = h_cnt;
  assign o_V_Counter   = v_cnt;
  assign o_Line_Start  = line_q;
  assign o_Frame_Start = frame_q;

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Produces the raster scan that the sprite renderer consumes.
- Provides free-running horizontal and vertical pixel counters, and active-low HSync/VSync delayed to line up with the renderer's pixel pipeline.
- Provides a visible-area flag and per-frame/per-line strobes for game logic (frog/car position updates).
- Sits between the top level and the sprite display block, once per VGA output.

Parameters:
H_VISIBLE_AREA, 640, visible pixels per line
H_FRONT_PORCH, 16, pixels after visible area before HSync
H_SYNC_PULSE, 96, HSync low width in pixels
H_BACK_PORCH, 48, pixels after HSync before next line
V_VISIBLE_AREA, 480, visible lines per frame
V_FRONT_PORCH, 10, lines after visible area before VSync
V_SYNC_PULSE, 2, VSync low width in lines
V_BACK_PORCH, 33, lines after VSync before next frame
SYNC_DELAY, 2, clock cycles of delay on HSync/VSync/Visible to match renderer latency (0..7)

Ports:
i_Clk  in  1  pixel clock
i_Rst_L  in  1  asynchronous active-low reset
i_Enable  in  1  advance counters when high; hold when low
o_H_Counter  out  10  current column, 0..H_TOTAL-1
o_V_Counter  out  10  current line, 0..V_TOTAL-1
o_HSync  out  1  active-low horizontal sync, delayed SYNC_DELAY
o_VSync  out  1  active-low vertical sync, delayed SYNC_DELAY
o_Visible  out  1  high inside visible area, delayed SYNC_DELAY
o_Line_Start  out  1  one-cycle strobe, H counter wrapped to 0
o_Frame_Start  out  1  one-cycle strobe, H and V both wrapped to 0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525). Counters are 10-bit unsigned; totals must be ≤ 1024 (elaboration check).
- Reset (i_Rst_L low, asynchronous, regardless of clock):
  - o_H_Counter = 0, o_V_Counter = 0.
  - o_HSync = 1, o_VSync = 1, o_Visible = 0.
  - Both strobes = 0.
  - Every delay-stage holds its inactive value: sync 1, visible 0.
- Reset release: the first rising edge with i_Rst_L high and i_Enable high moves the H counter to 1. No strobe is issued for the post-reset (0,0).
- Counting, per rising edge with i_Enable = 1:
  - H < H_TOTAL-1: H += 1.
  - H = H_TOTAL-1: H <= 0 and V advances; V = V_TOTAL-1 wraps to 0, else V += 1.
- i_Enable = 0: both counters hold; strobes are forced 0 that cycle.
- o_Line_Start: registered; high exactly the one cycle in which the counters first read H = 0 after a wrap. It is never high for two consecutive cycles, even if i_Enable drops while H = 0.
- o_Frame_Start: same as o_Line_Start, and additionally requires V = 0 after a V wrap.
- Raw decode, combinational from the registered counters:
  - hs_raw low iff H_VISIBLE_AREA+H_FRONT_PORCH ≤ H < H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE.
  - vs_raw low iff the V counter falls in the equivalent V window. VSync transitions therefore align with H = 0.
  - vis_raw = (H < H_VISIBLE_AREA) and (V < V_VISIBLE_AREA).
- Delay line:
  - hs_raw, vs_raw and vis_raw pass through a SYNC_DELAY-stage shift register that shifts every clock, independent of i_Enable. The output at cycle t equals the raw value at cycle t-SYNC_DELAY.
  - SYNC_DELAY = 0 drives the outputs directly from the raw decode.
- Counters and strobes are not delayed. The renderer uses the counters to address sprites; the syncs/visible flag then line up with its registered pixel output.
- Reset mid-frame: all state returns to reset values immediately, including delay stages, so no partial sync pulse is emitted after release.

Test Plan:
- Reset, then release with i_Enable=1 → after 10 edges H=10, V=0; HSync=VSync=1, Visible=1 from edge 2 onward (SYNC_DELAY=2); no strobe seen.
- Run one line → at H=799 the next edge gives H=0, V=1, o_Line_Start high exactly 1 cycle, o_Frame_Start low.
- HSync window → o_HSync low for exactly 96 consecutive cycles, first low while o_H_Counter=658 (656+2), high again at 754; repeats every 800 cycles.
- Full frame → VSync low from counter (2,490) through (1,492) (2-cycle shift, spanning 1600 cycles); o_Frame_Start pulses once, 420000 cycles after the first wrap reference, with counters (0,0); Visible high for 640×480 cycles per frame.
- Enable gating → drop i_Enable for 50 cycles at H=799, V=524: counters hold, no strobes; on re-enable exactly one o_Line_Start and one o_Frame_Start fire with counters (0,0).
- Async reset at H=700 (inside HSync), V=200, between clock edges → outputs go to reset values immediately; after release HSync stays 1 until H reaches 658 of the next line.
